// File: rtl/bnn_neuron_acc.sv
// ---------------------------------------------------------------------------
// bnn_neuron_acc
//
// Sequential accumulator for one binary neuron. A neuron is started from IDLE.
// The packed activation and weight vectors are then walked LSB first, one bit
// pair per cycle. Each pair drives a 1-bit add/sub ALU step on the
// accumulator: a matching pair adds 1 and a mismatching pair subtracts 1. The
// accumulator starts from the signed bias. When the neuron is finished, the
// result is presented with a valid/ready handshake.
//
// Parameters:
//   N      number of input/weight bit pairs (2..64)
//   ACC_W  signed accumulator / ALU width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a neuron (sampled only in IDLE)
//   x_vec      packed binary activations (0 = -1, 1 = +1)
//   w_vec      packed binary weights, same encoding
//   bias       signed bias preloaded into the accumulator
//   busy       high while accumulating or holding a result
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts the result
//   acc_out    signed accumulator value
//   act_out    sign activation: 1 when acc_out >= 0
//   sat_flag   sticky saturation indicator (only with BNN_ACC_SAT_EN)
//
// Optional feature macro: BNN_ACC_SAT_EN
//   Defined   -> each ALU step saturates at the signed limits, and the sticky
//                sat_flag output reports that this happened.
//   Undefined -> the ALU wraps modulo 2^ACC_W and there is no sat_flag port.
// ---------------------------------------------------------------------------
module bnn_neuron_acc #(
  parameter int N     = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     x_vec,
  input  logic [N-1:0]     w_vec,
  input  logic [ACC_W-1:0] bias,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             act_out
`ifdef BNN_ACC_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_ZERO = ACC_W'(0);
`ifdef BNN_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 1-bit add/sub ALU: the A operand is the constant 1 (its LSB is tied
  // high), and the B operand is the accumulator. op = 1 selects subtract.
  function automatic logic [ACC_W-1:0] alu_sum(input logic op,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] a;
    a = ACC_ONE;
    if (op) begin
      alu_sum = b - a;
    end else begin
      alu_sum = b + a;
    end
  endfunction

`ifdef BNN_ACC_SAT_EN
  // Overflow of a single +/-1 step happens only when the step starts at the
  // signed limit in the direction of the step.
  function automatic logic alu_ovf(input logic op,
                                   input logic [ACC_W-1:0] b);
    if (op) begin
      alu_ovf = (b == ACC_MIN);
    end else begin
      alu_ovf = (b == ACC_MAX);
    end
  endfunction
`endif

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [N-1:0]     x_sh_r, x_sh_s;
  logic [N-1:0]     w_sh_r, w_sh_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic             act_r;
  logic             busy_r;
  logic             valid_r;
  logic             alu_op_s;
  logic [ACC_W-1:0] alu_out_s;
`ifdef BNN_ACC_SAT_EN
  logic             sat_r, sat_s;
  logic             alu_ovf_s;
`endif

  // ALU operand selection for the current bit pair.
  always_comb begin
    alu_op_s  = x_sh_r[cnt_r] ^ w_sh_r[cnt_r];
    alu_out_s = alu_sum(alu_op_s, acc_r);
`ifdef BNN_ACC_SAT_EN
    alu_ovf_s = alu_ovf(alu_op_s, acc_r);
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    x_sh_s  = x_sh_r;
    w_sh_s  = w_sh_r;
    acc_s   = acc_r;
`ifdef BNN_ACC_SAT_EN
    sat_s   = sat_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          x_sh_s  = x_vec;
          w_sh_s  = w_vec;
          acc_s   = bias;
          cnt_s   = CNT_ZERO;
`ifdef BNN_ACC_SAT_EN
          sat_s   = 1'b0;
`endif
          state_s = ST_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
`ifdef BNN_ACC_SAT_EN
        // A saturating step holds the limit value and records the event.
        if (alu_ovf_s) begin
          acc_s = acc_r;
          sat_s = 1'b1;
        end else begin
          acc_s = alu_out_s;
        end
`else
        acc_s = alu_out_s;
`endif
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      x_sh_r  <= {N{1'b0}};
      w_sh_r  <= {N{1'b0}};
      acc_r   <= ACC_ZERO;
      act_r   <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
`ifdef BNN_ACC_SAT_EN
      sat_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      x_sh_r  <= x_sh_s;
      w_sh_r  <= w_sh_s;
      acc_r   <= acc_s;
      // The activation is registered together with the accumulator, so it
      // always matches the sign of acc_out.
      act_r   <= ~acc_s[ACC_W-1];
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_DONE);
`ifdef BNN_ACC_SAT_EN
      sat_r   <= sat_s;
`endif
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign acc_out   = acc_r;
  assign act_out   = act_r;
`ifdef BNN_ACC_SAT_EN
  assign sat_flag  = sat_r;
`endif

endmodule

// File: tb/tb_bnn_neuron_acc.sv
// ---------------------------------------------------------------------------
// tb_bnn_neuron_acc
//
// Directed testbench for bnn_neuron_acc (N=8, ACC_W=12). The stimulus pushes
// the hand-computed result of each neuron into a queue. A monitor pops and
// compares that result when the DUT hands it over on out_valid & out_ready.
// Latency, busy, hold-stability and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_bnn_neuron_acc;
  localparam int N     = 8;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [N-1:0]     x_vec;
  logic [N-1:0]     w_vec;
  logic [ACC_W-1:0] bias;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             act_out;
`ifdef BNN_ACC_SAT_EN
  logic             sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [ACC_W:0] exp_q[$];  // {act, acc}
  logic [ACC_W:0] mon_e;

  always #5 clk = ~clk;

  bnn_neuron_acc #(.N(N), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_vec     (x_vec),
    .w_vec     (w_vec),
    .bias      (bias),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .act_out   (act_out)
`ifdef BNN_ACC_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: compare on every handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got acc %0h with no expected entry", acc_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("acc_out", {20'd0, acc_out}, {20'd0, mon_e[ACC_W-1:0]});
        chk("act_out", {31'd0, act_out}, {31'd0, mon_e[ACC_W]});
      end
    end
  end

  // One neuron: start it, measure the latency, hold for 'hold' cycles, and
  // then accept the result (with start asserted on the handshake edge).
  task automatic run(input logic [N-1:0] x, input logic [N-1:0] w,
                     input logic [ACC_W-1:0] b, input logic [ACC_W-1:0] ea,
                     input logic eact, input int hold, input logic esat);
    int lat;
    logic [ACC_W-1:0] held;
    @(negedge clk);
    x_vec = x; w_vec = w; bias = b; start = 1'b1;
    exp_q.push_back({eact, ea});
    @(posedge clk); #1;
    start = 1'b0; x_vec = ~x; w_vec = x; bias = ~b;
    chk("busy_acc", {31'd0, busy}, 32'd1);
    chk("valid_acc", {31'd0, out_valid}, 32'd0);
`ifdef BNN_ACC_SAT_EN
    chk("sat_clear", {31'd0, sat_flag}, 32'd0);
`endif
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N);
    held = acc_out;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      x_vec = x_vec + 8'd1;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_acc", {20'd0, acc_out}, {20'd0, held});
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
`ifdef BNN_ACC_SAT_EN
    chk("sat_flag", {31'd0, sat_flag}, {31'd0, esat});
`endif
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_acc", {20'd0, acc_out}, {20'd0, held});
    @(posedge clk); #1;
    chk("idle_busy2", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    x_vec = 8'h00; w_vec = 8'h00; bias = 12'h000;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc", {20'd0, acc_out}, 32'd0);
    chk("rst_act", {31'd0, act_out}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(8'hFF, 8'hFF, 12'h000, 12'h008, 1'b1, 0, 1'b0);
    run(8'h00, 8'hFF, 12'h003, 12'hFFB, 1'b0, 0, 1'b0);
    run(8'hF0, 8'hFF, 12'h000, 12'h000, 1'b1, 5, 1'b0);
    run(8'h0F, 8'h33, 12'hFFF, 12'hFFF, 1'b0, 1, 1'b0);
    run(8'h00, 8'h00, 12'h800, 12'h808, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a run, with cnt = 3.
    @(negedge clk);
    x_vec = 8'hFF; w_vec = 8'hFF; bias = 12'h005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_acc", {20'd0, acc_out}, 32'd0);
    chk("arst_act", {31'd0, act_out}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);

    run(8'hAA, 8'hAA, 12'hFF8, 12'h000, 1'b1, 0, 1'b0);
`ifdef BNN_ACC_SAT_EN
    run(8'hFF, 8'hFF, 12'h7FF, 12'h7FF, 1'b1, 0, 1'b1);
    run(8'h00, 8'hFF, 12'h800, 12'h800, 1'b0, 0, 1'b1);
    run(8'hFF, 8'hFF, 12'h000, 12'h008, 1'b1, 0, 1'b0);
`else
    run(8'hFF, 8'hFF, 12'h7FF, 12'h807, 1'b0, 0, 1'b0);
    run(8'h00, 8'hFF, 12'h800, 12'h7F8, 1'b1, 0, 1'b0);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_neuron_acc.md
Name: bnn_neuron_acc

Overview:
- Sequential accumulator stage for one binary neuron.
- Feeds the existing 1-bit add/sub ALU and consumes its result. Owns the accumulator register, the bit-serial sequencing over the packed input/weight vectors, bias preload, sign activation and output handshake.
- Sits between the input/weight buffer (upstream) and the activation writeback (downstream).

Parameters:
- N, 8, number of input/weight bit pairs per neuron (2..64).
- ACC_W, 12, accumulator width in bits, signed two's complement; must equal the ALU width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  request to begin a neuron; sampled only in IDLE.
- x_vec  input  N  packed binary activations; bit i = input i; 0 encodes -1, 1 encodes +1.
- w_vec  input  N  packed binary weights, same encoding.
- bias  input  ACC_W  signed bias, preloaded into the accumulator.
- busy  output  1  high in ACC and DONE.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  signed accumulator value.
- act_out  output  1  sign activation: 1 when acc_out >= 0, else 0.

Behaviour:
- Reset (rst_n low, any state, any time): state=IDLE, acc=0, cnt=0, x/w shadow registers=0, busy=0, out_valid=0, acc_out=0, act_out=1.
  - Takes effect immediately and asynchronously; an in-flight neuron is discarded.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - On a clk edge with start=1: latch x_vec and w_vec into shadow registers, acc<=bias, cnt<=0, go to ACC.
  - start=0: stay in IDLE.
- ACC, one bit per cycle, LSB first:
  - alu_op = x_sh[cnt] ^ w_sh[cnt]. Encoding: 0 = add 1 (bits agree), 1 = subtract 1 (bits disagree).
  - ALU B operand = acc; LSB operand tied to 1; acc<=alu_out.
  - cnt increments each cycle. On the edge processing cnt=N-1, go to DONE.
- Arithmetic:
  - ACC_W-bit signed; overflow wraps modulo 2^ACC_W (default build).
  - Final value = bias + (matches - mismatches) = bias + 2*popcount(~(x^w)) - N.
- DONE:
  - out_valid=1; acc_out and act_out held stable.
  - act_out = ~acc[ACC_W-1].
  - On an edge with out_valid & out_ready: go to IDLE, out_valid<=0.
  - acc_out keeps its last value in IDLE until the next start.
- Latency: start sampled at edge k; out_valid rises after edge k+N and stays high until accepted.
- start is ignored in ACC and DONE. There is no queueing.
- x_vec, w_vec and bias may change freely after the start edge.
- A start in the same cycle as the handshake is ignored. At least one IDLE cycle separates neurons.
- out_ready is a don't-care outside DONE.

Optional Feature:
- Macro: BNN_ACC_SAT_EN.
- Defined: each ALU result is saturated.
  - Add at acc = 2^(ACC_W-1)-1 holds that value.
  - Subtract at acc = -2^(ACC_W-1) holds that value.
  - The sticky flag sat_flag is set and cleared on start or reset. sat_flag is an extra output port, 1 bit, present only when the macro is defined.
- Undefined: pure wrap-around arithmetic; no sat_flag port.

Test Plan:
- N=8, ACC_W=12, x=8'hFF, w=8'hFF, bias=0, start pulse -> out_valid exactly 8 cycles after the start edge, acc_out=8, act_out=1.
- x=8'h00, w=8'hFF, bias=3 -> acc_out=-5 (12'hFFB), act_out=0.
- x=8'hF0, w=8'hFF, bias=0 -> acc_out=0, act_out=1. Then:
  - Hold out_ready=0 for 5 cycles while pulsing start and changing x_vec -> outputs stable, start ignored.
  - Raise out_ready -> IDLE next cycle, out_valid=0.
- Assert rst_n=0 asynchronously at cnt=3 of a run -> out_valid=0, busy=0, acc_out=0 immediately. Then start a fresh run with x=w=8'hAA, bias=-8 -> acc_out=0, act_out=1.
- Default build: bias=2047, x=w=8'hFF -> acc_out=-2041 (wrap), act_out=0.
- With BNN_ACC_SAT_EN: same stimulus -> acc_out=2047, act_out=1, sat_flag=1; next start clears sat_flag.
